cond_resolve_stage: RTL and testbench

//  Condition-resolution stage directly downstream of the combinational condition evaluator.
//  - Holds the architectural ALU status flags (Z,N,V,C).
//  - Accepts branch/conditional-op requests carrying a 5-bit condition code and a tag.
//  - Resolves taken/not-taken against the flags and returns the result through a registered

---
 rtl/cond_resolve_stage.sv | 117 +++++++++++
 tb/tb_cond_resolve_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cond_resolve_stage.sv
// Condition-resolution stage: holds ALU flags, resolves 5-bit condition codes into a
// registered valid/ready result, and keeps saturating taken/total counters.
// Optional macro COND_FLAG_FWD_EN forwards same-cycle flag writes into the resolve.
module cond_resolve_stage #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flag_wr,
   input  logic             flag_z,
   input  logic             flag_n,
   input  logic             flag_v,
   input  logic             flag_c,
   input  logic             cond_valid,
   output logic             cond_ready,
   input  logic [4:0]       cond_code,
   input  logic [TAG_W-1:0] cond_tag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_taken,
   output logic [TAG_W-1:0] res_tag,
   output logic [3:0]       flags_q,
   output logic [CNT_W-1:0] stat_taken,
   output logic [CNT_W-1:0] stat_total
);

   logic [3:0]       r_flags;
   logic             r_res_valid;
   logic             r_res_taken;
   logic [TAG_W-1:0] r_res_tag;
   logic [CNT_W-1:0] r_stat_taken;
   logic [CNT_W-1:0] r_stat_total;

   logic [3:0] w_f;
   logic       w_n, w_z, w_c, w_v;
   logic       w_sel;
   logic       w_taken;
   logic       w_acc;

`ifdef COND_FLAG_FWD_EN
   assign w_f = flag_wr ? {flag_n, flag_z, flag_c, flag_v} : r_flags;
`else
   assign w_f = r_flags;
`endif

   assign {w_n, w_z, w_c, w_v} = w_f;

   always_comb begin
      w_sel = 1'b0;
      case (cond_code[3:0])
         4'd0:  w_sel = w_z;
         4'd1:  w_sel = ~w_z;
         4'd2:  w_sel = w_c;
         4'd3:  w_sel = ~w_c;
         4'd4:  w_sel = w_n;
         4'd5:  w_sel = ~w_n;
         4'd6:  w_sel = w_v;
         4'd7:  w_sel = ~w_v;
         4'd8:  w_sel = w_c & ~w_z;
         4'd9:  w_sel = ~w_c | w_z;
         4'd10: w_sel = (w_n == w_v);
         4'd11: w_sel = (w_n != w_v);
         4'd12: w_sel = ~w_z & (w_n == w_v);
         4'd13: w_sel = w_z | (w_n != w_v);
         4'd14: w_sel = 1'b1;
         default: w_sel = 1'b0;
      endcase
   end

   assign w_taken    = w_sel ^ cond_code[4];
   // Single-entry slot: a draining result frees the slot in the same cycle.
   assign cond_ready = ~r_res_valid | res_ready;
   assign w_acc      = cond_valid & cond_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= 4'b0000;
      end else if (flag_wr) begin
         r_flags <= {flag_n, flag_z, flag_c, flag_v};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_valid <= 1'b0;
         r_res_taken <= 1'b0;
         r_res_tag   <= '0;
      end else if (w_acc) begin
         r_res_valid <= 1'b1;
         r_res_taken <= w_taken;
         r_res_tag   <= cond_tag;
      end else if (res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_taken <= '0;
         r_stat_total <= '0;
      end else if (w_acc) begin
         if (r_stat_total != '1)
            r_stat_total <= r_stat_total + 1'b1;
         if (w_taken && (r_stat_taken != '1))
            r_stat_taken <= r_stat_taken + 1'b1;
      end
   end

   assign res_valid  = r_res_valid;
   assign res_taken  = r_res_taken;
   assign res_tag    = r_res_tag;
   assign flags_q    = r_flags;
   assign stat_taken = r_stat_taken;
   assign stat_total = r_stat_total;

endmodule

// File: tb/tb_cond_resolve_stage.sv
// Directed bench for cond_resolve_stage: vector table for condition decode plus
// hand sequences for backpressure, forwarding, async reset and counter saturation.
module tb_cond_resolve_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flag_wr, flag_z, flag_n, flag_v, flag_c;
   logic       cond_valid, cond_ready;
   logic [4:0] cond_code;
   logic [3:0] cond_tag;
   logic       res_valid, res_ready, res_taken;
   logic [3:0] res_tag;
   logic [3:0] flags_q;
   logic [15:0] stat_taken, stat_total;

   // Narrow-counter instance used only for saturation.
   logic       s_cond_valid, s_cond_ready, s_res_valid, s_res_taken;
   logic [3:0] s_res_tag, s_flags_q, s_stat_taken, s_stat_total;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cond_resolve_stage #(.TAG_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flag_wr(flag_wr), .flag_z(flag_z), .flag_n(flag_n),
      .flag_v(flag_v), .flag_c(flag_c), .cond_valid(cond_valid), .cond_ready(cond_ready),
      .cond_code(cond_code), .cond_tag(cond_tag), .res_valid(res_valid),
      .res_ready(res_ready), .res_taken(res_taken), .res_tag(res_tag), .flags_q(flags_q),
      .stat_taken(stat_taken), .stat_total(stat_total)
   );

   cond_resolve_stage #(.TAG_W(4), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flag_wr(1'b0), .flag_z(1'b0), .flag_n(1'b0),
      .flag_v(1'b0), .flag_c(1'b0), .cond_valid(s_cond_valid), .cond_ready(s_cond_ready),
      .cond_code(5'd14), .cond_tag(4'd3), .res_valid(s_res_valid),
      .res_ready(1'b1), .res_taken(s_res_taken), .res_tag(s_res_tag), .flags_q(s_flags_q),
      .stat_taken(s_stat_taken), .stat_total(s_stat_total)
   );

   typedef struct {
      logic [3:0] flags;   // {N,Z,C,V}
      logic [4:0] code;
      logic       exp;
   } vec_t;

   vec_t vecs[40];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [0:15] sweep;
      int          exp_taken_cnt;
      logic        fwd_exp;

      rst_n = 1'b0; flag_wr = 0; flag_z = 0; flag_n = 0; flag_v = 0; flag_c = 0;
      cond_valid = 0; cond_code = '0; cond_tag = '0; res_ready = 1; s_cond_valid = 0;

      // Expected taken for codes 0..15 with only Z set.
      sweep = 16'b1001010101100110;
      for (int i = 0; i < 16; i++) begin
         vecs[i]      = '{4'b0100, {1'b0, 4'(i)}, sweep[i]};
         vecs[16 + i] = '{4'b0100, {1'b1, 4'(i)}, ~sweep[i]};
      end
      vecs[32] = '{4'b1000, 5'd11, 1'b1};  // N=1 V=0 LT
      vecs[33] = '{4'b1000, 5'd10, 1'b0};  // GE
      vecs[34] = '{4'b1001, 5'd10, 1'b1};  // N=1 V=1 GE
      vecs[35] = '{4'b1001, 5'd12, 1'b1};  // GT, Z=0
      vecs[36] = '{4'b0010, 5'd8,  1'b1};  // HI with C=1 Z=0
      vecs[37] = '{4'b0010, 5'd9,  1'b0};  // LS
      vecs[38] = '{4'b0001, 5'd6,  1'b1};  // VS
      vecs[39] = '{4'b1000, 5'd13, 1'b1};  // LE via N!=V

      #12;
      chk("rst_res_valid", {31'b0, res_valid}, 0);
      chk("rst_res_taken", {31'b0, res_taken}, 0);
      chk("rst_res_tag", {28'b0, res_tag}, 0);
      chk("rst_flags", {28'b0, flags_q}, 0);
      chk("rst_stat_total", {16'b0, stat_total}, 0);
      @(negedge clk); rst_n = 1'b1;

      exp_taken_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         flag_wr = 1; {flag_n, flag_z, flag_c, flag_v} = vecs[i].flags; cond_valid = 0;
         @(negedge clk);
         flag_wr = 0; cond_valid = 1; cond_code = vecs[i].code; cond_tag = 4'(i);
         tick();
         chk($sformatf("vec%0d_valid", i), {31'b0, res_valid}, 1);
         chk($sformatf("vec%0d_taken", i), {31'b0, res_taken}, {31'b0, vecs[i].exp});
         chk($sformatf("vec%0d_tag", i), {28'b0, res_tag}, i & 15);
         chk($sformatf("vec%0d_flags", i), {28'b0, flags_q}, {28'b0, vecs[i].flags});
         if (vecs[i].exp) exp_taken_cnt++;
         @(negedge clk); cond_valid = 0;
      end
      tick();
      chk("table_valid_drain", {31'b0, res_valid}, 0);
      chk("table_stat_total", {16'b0, stat_total}, 40);
      chk("table_stat_taken", {16'b0, stat_taken}, exp_taken_cnt);

      // Backpressure: result held while consumer stalls.
      @(negedge clk);
      res_ready = 0; cond_valid = 1; cond_code = 5'd14; cond_tag = 4'd5;
      tick();
      chk("bp_first_valid", {31'b0, res_valid}, 1);
      @(negedge clk);
      cond_code = 5'd15; cond_tag = 4'd6;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp_ready_low%0d", k), {31'b0, cond_ready}, 0);
         tick();
         chk($sformatf("bp_tag_hold%0d", k), {28'b0, res_tag}, 5);
         chk($sformatf("bp_taken_hold%0d", k), {31'b0, res_taken}, 1);
         chk($sformatf("bp_valid_hold%0d", k), {31'b0, res_valid}, 1);
         @(negedge clk);
      end
      res_ready = 1;
      #1;
      chk("bp_release_ready", {31'b0, cond_ready}, 1);
      tick();
      chk("bp_second_tag", {28'b0, res_tag}, 6);
      chk("bp_second_taken", {31'b0, res_taken}, 0);
      for (int k = 7; k < 10; k++) begin
         @(negedge clk);
         cond_code = 5'd14; cond_tag = 4'(k);
         tick();
         chk($sformatf("stream_tag%0d", k), {28'b0, res_tag}, k);
         chk($sformatf("stream_valid%0d", k), {31'b0, res_valid}, 1);
      end
      @(negedge clk); cond_valid = 0;
      tick();
      chk("stream_drain", {31'b0, res_valid}, 0);

      // Same-cycle flag write with an EQ request.
      @(negedge clk);
      flag_wr = 1; {flag_n, flag_z, flag_c, flag_v} = 4'b0000;
      @(negedge clk);
      flag_wr = 1; flag_z = 1; cond_valid = 1; cond_code = 5'd0; cond_tag = 4'd9;
`ifdef COND_FLAG_FWD_EN
      fwd_exp = 1'b1;
`else
      fwd_exp = 1'b0;
`endif
      tick();
      chk("fwd_same_cycle", {31'b0, res_taken}, {31'b0, fwd_exp});
      chk("fwd_flags_upd", {28'b0, flags_q}, 4'b0100);
      @(negedge clk);
      flag_wr = 0; cond_tag = 4'd10;
      tick();
      chk("fwd_next_eq", {31'b0, res_taken}, 1);
      chk("fwd_next_tag", {28'b0, res_tag}, 10);

      // Async reset with a result pending under backpressure.
      @(negedge clk);
      res_ready = 0; cond_code = 5'd14; cond_tag = 4'd12;
      tick();
      chk("mid_pre_valid", {31'b0, res_valid}, 1);
      @(negedge clk);
      cond_valid = 0; rst_n = 0;
      #1;
      chk("mid_rst_valid", {31'b0, res_valid}, 0);
      chk("mid_rst_flags", {28'b0, flags_q}, 0);
      chk("mid_rst_total", {16'b0, stat_total}, 0);
      chk("mid_rst_taken", {16'b0, stat_taken}, 0);
      chk("mid_rst_tag", {28'b0, res_tag}, 0);
      @(negedge clk); rst_n = 1; res_ready = 1;
      tick();
      chk("mid_no_replay", {31'b0, res_valid}, 0);

      // Saturation on the 4-bit counter instance.
      @(negedge clk); s_cond_valid = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("sat_total%0d", k), {28'b0, s_stat_total}, (k + 1 > 15) ? 15 : k + 1);
         chk($sformatf("sat_taken%0d", k), {28'b0, s_stat_taken}, (k + 1 > 15) ? 15 : k + 1);
         @(negedge clk);
      end
      s_cond_valid = 0;
      tick();
      chk("sat_hold_total", {28'b0, s_stat_total}, 15);
      chk("sat_hold_taken", {28'b0, s_stat_taken}, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
